ram8_arbiter: RTL and testbench

Two-port arbiter and access sequencer for an eight-word × 16-bit register bank built from the existing 16-bit register cells. It sits between two independent requesters (e.g. CPU data path and a debug/loader port) and the shared bank, serialising their reads and writes with round-robin fairness. The bank is internal to the block and has no reset; only control state is reset.

---
 rtl/ram8_arbiter_pkg.sv | 16 +
 rtl/ram8_arbiter_ram8.sv | 45 ++++
 rtl/ram8_arbiter.sv | 123 ++++++++++++
 tb/tb_ram8_arbiter.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/ram8_arbiter_pkg.sv
// ram8_arbiter_pkg
// Shared definitions for the two-port register-bank arbiter and for later
// multi-port memory controllers built on the same scheme.
//   state_t : sequencer states (ST_IDLE, ST_ACCESS)
//   PORT0/1 : port identifiers used for the latched selection and the pointer
package ram8_arbiter_pkg;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ACCESS = 1'b1
    } state_t;

    localparam logic PORT0 = 1'b0;
    localparam logic PORT1 = 1'b1;

endpackage

// File: rtl/ram8_arbiter_ram8.sv
// ram8_arbiter_ram8
// Register bank of 2^DEPTH_LOG2 words, one register cell per word, with a
// one-hot load decode and a combinational read mux. Contents have no reset.
// Ports:
//   clk    : clock, writes commit on the rising edge
//   load   : write enable for the word at addr
//   addr   : word address, shared by write and read
//   wdata  : write data
//   rdata  : combinational read of the word at addr
module ram8_arbiter_ram8 #(
    parameter int WIDTH      = 16,
    parameter int DEPTH_LOG2 = 3
) (
    input  logic                  clk,
    input  logic                  load,
    input  logic [DEPTH_LOG2-1:0] addr,
    input  logic [WIDTH-1:0]      wdata,
    output logic [WIDTH-1:0]      rdata
);

    localparam int DEPTH = 1 << DEPTH_LOG2;

    logic [DEPTH-1:0]            load_oh;
    logic [DEPTH-1:0][WIDTH-1:0] words;

    always_comb begin
        load_oh       = '0;
        load_oh[addr] = load;
    end

    for (genvar i = 0; i < DEPTH; i++) begin : g_word
        logic [WIDTH-1:0] q;

        always_ff @(posedge clk) begin
            if (load_oh[i]) begin
                q <= wdata;
            end
        end

        assign words[i] = q;
    end

    assign rdata = words[addr];

endmodule

// File: rtl/ram8_arbiter.sv
// ram8_arbiter
// Two-port round-robin arbiter and access sequencer for an internal
// eight-word register bank. Each accepted request occupies one ACCESS cycle;
// reads return data one cycle after the grant.
// Ports:
//   clk, reset         : clock and synchronous active-high reset
//   req0/1             : access request, held until the matching gnt
//   we0/1              : 1 = write, 0 = read
//   addr0/1, wdata0/1  : word address and write data for each port
//   gnt0/1             : one-cycle pulse during the access cycle
//   rvalid0/1          : one-cycle pulse, rdata holds that port's read result
//   rdata              : shared read data
//   busy               : high during the access cycle
module ram8_arbiter
    import ram8_arbiter_pkg::*;
#(
    parameter int WIDTH      = 16,
    parameter int DEPTH_LOG2 = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req0,
    input  logic                  req1,
    input  logic                  we0,
    input  logic                  we1,
    input  logic [DEPTH_LOG2-1:0] addr0,
    input  logic [DEPTH_LOG2-1:0] addr1,
    input  logic [WIDTH-1:0]      wdata0,
    input  logic [WIDTH-1:0]      wdata1,
    output logic                  gnt0,
    output logic                  gnt1,
    output logic                  rvalid0,
    output logic                  rvalid1,
    output logic [WIDTH-1:0]      rdata,
    output logic                  busy
);

    state_t                state, state_nx;
    logic                  ptr;
    logic                  sel, sel_nx;
    logic                  take;
    logic                  lat_we;
    logic [DEPTH_LOG2-1:0] lat_addr;
    logic [WIDTH-1:0]      lat_wdata;
    logic                  bank_load;
    logic [WIDTH-1:0]      bank_rdata;

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= ST_IDLE;
            ptr     <= PORT0;
            rvalid0 <= 1'b0;
            rvalid1 <= 1'b0;
            rdata   <= '0;
        end else begin
            state   <= state_nx;
            rvalid0 <= 1'b0;
            rvalid1 <= 1'b0;
            if (state == ST_ACCESS) begin
                ptr <= ~sel;
                if (!lat_we) begin
                    rdata <= bank_rdata;
                    if (sel == PORT1) begin
                        rvalid1 <= 1'b1;
                    end else begin
                        rvalid0 <= 1'b1;
                    end
                end
            end
        end
    end

    // Request latches only need to be valid during ACCESS, so they carry no reset.
    always_ff @(posedge clk) begin
        if (!reset && take) begin
            sel       <= sel_nx;
            lat_we    <= (sel_nx == PORT1) ? we1    : we0;
            lat_addr  <= (sel_nx == PORT1) ? addr1  : addr0;
            lat_wdata <= (sel_nx == PORT1) ? wdata1 : wdata0;
        end
    end

    always_comb begin
        state_nx = state;
        take     = 1'b0;
        sel_nx   = PORT0;
        gnt0     = 1'b0;
        gnt1     = 1'b0;
        busy     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (req0 || req1) begin
                    take     = 1'b1;
                    state_nx = ST_ACCESS;
                    // Contention goes to the pointer, otherwise to the sole requester.
                    sel_nx   = (req0 && req1) ? ptr : req1;
                end
            end
            ST_ACCESS: begin
                busy     = 1'b1;
                gnt0     = (sel == PORT0);
                gnt1     = (sel == PORT1);
                state_nx = ST_IDLE;
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    // A reset landing in the access cycle must abort the write.
    assign bank_load = (state == ST_ACCESS) && lat_we && !reset;

    ram8_arbiter_ram8 #(
        .WIDTH      (WIDTH),
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_ram8 (
        .clk   (clk),
        .load  (bank_load),
        .addr  (lat_addr),
        .wdata (lat_wdata),
        .rdata (bank_rdata)
    );

endmodule

// File: tb/tb_ram8_arbiter.sv
module tb_ram8_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        req0, req1, we0, we1;
    logic [2:0]  addr0, addr1;
    logic [15:0] wdata0, wdata1;
    logic        gnt0, gnt1, rvalid0, rvalid1, busy;
    logic [15:0] rdata;

    int checks = 0;
    int failures = 0;

    ram8_arbiter #(.WIDTH(16), .DEPTH_LOG2(3)) dut (
        .clk     (clk),
        .reset   (reset),
        .req0    (req0),
        .req1    (req1),
        .we0     (we0),
        .we1     (we1),
        .addr0   (addr0),
        .addr1   (addr1),
        .wdata0  (wdata0),
        .wdata1  (wdata1),
        .gnt0    (gnt0),
        .gnt1    (gnt1),
        .rvalid0 (rvalid0),
        .rvalid1 (rvalid1),
        .rdata   (rdata),
        .busy    (busy)
    );

    always #5 clk = ~clk;

    // Transaction-level reference: a bank array, a fairness pointer and the
    // one transaction currently being executed.
    logic [15:0] mem [8];
    bit          mem_ok [8];
    bit          m_ptr;
    bit          m_active;
    bit          m_sel;
    bit          m_we;
    logic [2:0]  m_addr;
    logic [15:0] m_wdata;
    bit          exp_g [2];
    bit          exp_rv [2];
    logic [15:0] exp_rdata;
    bit          rd_known;
    bit          pend [2];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Decide what the next cycle must show, given the inputs driven this cycle.
    task automatic predict();
        exp_g[0] = 0; exp_g[1] = 0; exp_rv[0] = 0; exp_rv[1] = 0;
        if (reset) begin
            m_ptr = 0; m_active = 0; exp_rdata = '0; rd_known = 1;
            return;
        end
        if (m_active) begin
            if (m_we) begin
                mem[m_addr] = m_wdata;
                mem_ok[m_addr] = 1;
            end else begin
                exp_rv[m_sel] = 1;
                exp_rdata = mem[m_addr];
                rd_known = mem_ok[m_addr];
            end
            m_ptr = !m_sel;
            m_active = 0;
        end else if (req0 || req1) begin
            if (req0 && req1) m_sel = m_ptr;
            else              m_sel = req1;
            m_we    = m_sel ? we1 : we0;
            m_addr  = m_sel ? addr1 : addr0;
            m_wdata = m_sel ? wdata1 : wdata0;
            m_active = 1;
            exp_g[m_sel] = 1;
        end
    endtask

    task automatic check_outputs();
        chk("gnt0", 32'(gnt0), 32'(exp_g[0]));
        chk("gnt1", 32'(gnt1), 32'(exp_g[1]));
        chk("busy", 32'(busy), 32'(m_active));
        chk("rvalid0", 32'(rvalid0), 32'(exp_rv[0]));
        chk("rvalid1", 32'(rvalid1), 32'(exp_rv[1]));
        if (rd_known) chk("rdata", 32'(rdata), 32'(exp_rdata));
    endtask

    task automatic step();
        predict();
        @(posedge clk);
        #1;
        check_outputs();
    endtask

    task automatic set_req(input int p, input logic r, input logic w, input logic [2:0] a, input logic [15:0] d);
        if (p == 0) begin
            req0 = r; we0 = w; addr0 = a; wdata0 = d;
        end else begin
            req1 = r; we1 = w; addr1 = a; wdata1 = d;
        end
    endtask

    task automatic wait_gnt(input int p);
        bit seen;
        seen = 0;
        for (int i = 0; i < 8 && !seen; i++) begin
            step();
            seen = (p == 0) ? gnt0 : gnt1;
        end
        chk("gnt_timeout", 32'(seen), 32'd1);
    endtask

    task automatic do_access(input int p, input logic w, input logic [2:0] a, input logic [15:0] d);
        set_req(p, 1'b1, w, a, d);
        wait_gnt(p);
        set_req(p, 1'b0, 1'b0, 3'd0, 16'd0);
        step();
    endtask

    initial begin
        int cnt [2];
        int last;
        int grants;
        logic [15:0] v;

        reset = 1'b1;
        set_req(0, 1'b0, 1'b0, 3'd0, 16'd0);
        set_req(1, 1'b0, 1'b0, 3'd0, 16'd0);
        for (int i = 0; i < 8; i++) mem_ok[i] = 0;
        m_ptr = 0; m_active = 0; rd_known = 0; exp_rdata = '0;

        // Reset then idle
        step(); step();
        reset = 1'b0;
        for (int i = 0; i < 5; i++) step();

        // Single-port write then read
        do_access(0, 1'b1, 3'd5, 16'h1234);
        do_access(0, 1'b0, 3'd5, 16'h0000);
        chk("read_back_5", 32'(rdata), 32'h1234);

        // Mid-stream reset for 2 cycles
        reset = 1'b1; step(); step(); reset = 1'b0; step();

        // Simultaneous requests: port 0 write, port 1 read of the same word
        set_req(0, 1'b1, 1'b1, 3'd2, 16'hAAAA);
        set_req(1, 1'b1, 1'b0, 3'd2, 16'h0000);
        wait_gnt(0);
        set_req(0, 1'b0, 1'b0, 3'd0, 16'd0);
        wait_gnt(1);
        set_req(1, 1'b0, 1'b0, 3'd0, 16'd0);
        step();
        chk("raw_rdata", 32'(rdata), 32'hAAAA);
        chk("raw_rvalid1", 32'(rvalid1), 32'd1);

        // Sustained contention: 8 accesses must alternate
        cnt[0] = 0; cnt[1] = 0; last = -1; grants = 0;
        set_req(0, 1'b1, 1'b0, 3'd5, 16'd0);
        set_req(1, 1'b1, 1'b0, 3'd2, 16'd0);
        for (int i = 0; i < 24 && grants < 8; i++) begin
            step();
            if (gnt0 || gnt1) begin
                int g;
                g = gnt1 ? 1 : 0;
                if (last >= 0) chk("alternate", 32'(g), 32'(1 - last));
                last = g;
                cnt[g]++;
                grants++;
            end
        end
        set_req(0, 1'b0, 1'b0, 3'd0, 16'd0);
        set_req(1, 1'b0, 1'b0, 3'd0, 16'd0);
        step();
        chk("contention_port0", 32'(cnt[0]), 32'd4);
        chk("contention_port1", 32'(cnt[1]), 32'd4);

        // Reset landing on a write access
        do_access(1, 1'b1, 3'd7, 16'h0001);
        set_req(1, 1'b1, 1'b1, 3'd7, 16'hBEEF);
        wait_gnt(1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        set_req(1, 1'b0, 1'b0, 3'd0, 16'd0);
        step();
        do_access(0, 1'b0, 3'd7, 16'd0);
        chk("abort_write_7", 32'(rdata), 32'h0001);

        // Address sweep across alternating ports
        for (int a = 0; a < 8; a++) begin
            v = 16'(a * 16'h1111);
            do_access(a % 2, 1'b1, 3'(a), v);
        end
        for (int a = 0; a < 8; a++) begin
            v = 16'(a * 16'h1111);
            do_access((a + 1) % 2, 1'b0, 3'(a), 16'd0);
            chk("sweep_read", 32'(rdata), 32'(v));
        end

        // Randomized traffic from both ports
        pend[0] = 0; pend[1] = 0;
        for (int c = 0; c < 400; c++) begin
            for (int p = 0; p < 2; p++) begin
                if ((p == 0) ? gnt0 : gnt1) pend[p] = 0;
                if (!pend[p]) begin
                    if ($urandom_range(1, 0) == 1) begin
                        pend[p] = 1;
                        set_req(p, 1'b1, 1'($urandom_range(1, 0)), 3'($urandom_range(7, 0)), 16'($urandom));
                    end else begin
                        set_req(p, 1'b0, 1'b0, 3'd0, 16'd0);
                    end
                end
            end
            step();
        end
        set_req(0, 1'b0, 1'b0, 3'd0, 16'd0);
        set_req(1, 1'b0, 1'b0, 3'd0, 16'd0);
        step(); step(); step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
